// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Two-channel push-button conditioner. Each raw board key is brought into the
//   i_clk domain through a two-flop synchroniser, normalised so that 1 means
//   "pressed", and then filtered by its own counter FSM. A key change is only
//   accepted once the synchronised level has held for DEBOUNCE_CNT consecutive
//   cycles. On acceptance the clean level toggles and a one-cycle press or
//   release pulse is emitted in the same cycle.
//
//   Parameters
//     DEBOUNCE_CNT   : stable cycles needed to accept a change (2 .. 2**24)
//     KEY_ACTIVE_LOW : 1 = raw key reads 0 when pressed, 0 = reads 1 when pressed
//
//   Ports
//     i_clk          : system clock
//     i_rst_n        : asynchronous active-low reset
//     i_key0/i_key1  : raw, asynchronous, bouncing key pins
//     o_key0/o_key1  : debounced key levels, 1 = pressed
//     o_keyN_press   : one-cycle pulse when a press of key N is accepted
//     o_keyN_rel     : one-cycle pulse when a release of key N is accepted
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// key_debounce_chan
//   Debounce FSM for one already-synchronised, already-normalised key.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   UP      | key accepted as released, level 0
//   WAIT_DN | candidate press, counting consecutive pressed cycles
//   DOWN    | key accepted as pressed, level 1
//   WAIT_UP | candidate release, counting consecutive released cycles
//
//   Ports
//     i_clk, i_rst_n : clock and asynchronous active-low reset
//     i_s            : synchronised key, 1 = pressed
//     o_level        : debounced level
//     o_press        : one-cycle pulse on accepted press
//     o_rel          : one-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module key_debounce_chan #(
    parameter int unsigned DEBOUNCE_CNT = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_s,
    output logic o_level,
    output logic o_press,
    output logic o_rel
);

    localparam int CNT_W = $clog2(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        UP      = 2'd0,
        WAIT_DN = 2'd1,
        DOWN    = 2'd2,
        WAIT_UP = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             rel_q;

    // The cycle that first sees the new level counts as 1, so reaching
    // DEBOUNCE_CNT-1 while the level is still held means DEBOUNCE_CNT
    // consecutive samples. Any disagreeing sample drops back to the stable
    // state with the count cleared, so bounces never accumulate.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= UP;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            case (state_q)
                UP: begin
                    if (i_s) begin
                        state_q <= WAIT_DN;
                        cnt_q   <= CNT_ONE;
                    end
                end
                WAIT_DN: begin
                    if (!i_s) begin
                        state_q <= UP;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= DOWN;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                DOWN: begin
                    if (!i_s) begin
                        state_q <= WAIT_UP;
                        cnt_q   <= CNT_ONE;
                    end
                end
                WAIT_UP: begin
                    if (i_s) begin
                        state_q <= DOWN;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= UP;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        rel_q   <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= UP;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_level = level_q;
    assign o_press = press_q;
    assign o_rel   = rel_q;

endmodule

// -----------------------------------------------------------------------------
// key_debounce (top)
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int unsigned DEBOUNCE_CNT   = 1000000,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key0,
    input  logic i_key1,
    output logic o_key0,
    output logic o_key1,
    output logic o_key0_press,
    output logic o_key0_rel,
    output logic o_key1_press,
    output logic o_key1_rel
);

    // Raw pin level of a key that is not being pressed. The synchronisers
    // reset to it so that nothing looks like a press coming out of reset.
    localparam logic RELEASED = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [1:0] key0_sync_q;
    logic [1:0] key1_sync_q;
    logic       s0;
    logic       s1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            key0_sync_q <= {2{RELEASED}};
            key1_sync_q <= {2{RELEASED}};
        end else begin
            key0_sync_q <= {key0_sync_q[0], i_key0};
            key1_sync_q <= {key1_sync_q[0], i_key1};
        end
    end

    // Normalise to pressed = 1.
    assign s0 = key0_sync_q[1] ^ RELEASED;
    assign s1 = key1_sync_q[1] ^ RELEASED;

    key_debounce_chan #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_chan0 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_s     (s0),
        .o_level (o_key0),
        .o_press (o_key0_press),
        .o_rel   (o_key0_rel)
    );

    key_debounce_chan #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_chan1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_s     (s1),
        .o_level (o_key1),
        .o_press (o_key1_press),
        .o_rel   (o_key1_rel)
    );

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//   Bench for key_debounce with DEBOUNCE_CNT = 8, active-low keys, 20 ns clock.
//   The reference model keeps a shift history of the pressed/released value
//   sampled from each pin at every clock edge. The synchroniser makes the
//   filter see the sample from two edges earlier, so the clean level flips on
//   an edge exactly when the DEBOUNCE_CNT samples taken two to DEBOUNCE_CNT+1
//   edges earlier all disagree with the current level.
// -----------------------------------------------------------------------------
module tb_key_debounce;

    localparam int D = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic key0  = 1'b1;
    logic key1  = 1'b1;

    logic o_key0, o_key1;
    logic o_key0_press, o_key0_rel, o_key1_press, o_key1_rel;

    int checks = 0;
    int errors = 0;
    int p0cnt  = 0;
    int r0cnt  = 0;

    always #10 clk = ~clk;

    key_debounce #(
        .DEBOUNCE_CNT   (D),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_key0       (key0),
        .i_key1       (key1),
        .o_key0       (o_key0),
        .o_key1       (o_key1),
        .o_key0_press (o_key0_press),
        .o_key0_rel   (o_key0_rel),
        .o_key1_press (o_key1_press),
        .o_key1_rel   (o_key1_rel)
    );

    // ---------------- reference model ----------------
    logic [D+1:0] h0, h1;   // bit 0 = pressed value sampled at the latest edge
    logic e_l0, e_p0, e_r0, e_l1, e_p1, e_r1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0 <= '0; h1 <= '0;
            e_l0 <= 1'b0; e_p0 <= 1'b0; e_r0 <= 1'b0;
            e_l1 <= 1'b0; e_p1 <= 1'b0; e_r1 <= 1'b0;
        end else begin
            h0 <= {h0[D:0], ~key0};
            h1 <= {h1[D:0], ~key1};
            // h[D:1] before the shift = samples from 2 .. D+1 edges ago
            if (h0[D:1] == {D{~e_l0}}) begin
                e_l0 <= ~e_l0; e_p0 <= ~e_l0; e_r0 <= e_l0;
            end else begin
                e_p0 <= 1'b0; e_r0 <= 1'b0;
            end
            if (h1[D:1] == {D{~e_l1}}) begin
                e_l1 <= ~e_l1; e_p1 <= ~e_l1; e_r1 <= e_l1;
            end else begin
                e_p1 <= 1'b0; e_r1 <= 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Advance to 1 ns after the next rising edge and compare every output
    // against the model.
    task automatic tick();
        logic [5:0] got, req;
        @(posedge clk);
        #1;
        got = {o_key0, o_key0_press, o_key0_rel, o_key1, o_key1_press, o_key1_rel};
        req = {e_l0, e_p0, e_r0, e_l1, e_p1, e_r1};
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL model_cmp at %0t: got %b required %b", $time, got, req);
        end
        p0cnt += int'(o_key0_press);
        r0cnt += int'(o_key0_rel);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Counts edges from the first sampling edge (numbered 1) until the key
    // level reaches want, then checks the count and the matching pulse.
    task automatic wait_flip(input int key, input logic want, input int exp_n,
                             input string name);
        int   n    = 0;
        bit   seen = 1'b0;
        logic lv, pl;
        while (!seen && n < 30) begin
            tick();
            n++;
            lv = (key == 1) ? o_key1 : o_key0;
            if (lv === want) seen = 1'b1;
        end
        if (key == 1) pl = want ? o_key1_press : o_key1_rel;
        else          pl = want ? o_key0_press : o_key0_rel;
        check({name, "_latency"}, n, exp_n);
        check({name, "_pulse"}, int'(pl), 1);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic k0;
        logic k1;
        int   cycles;
        logic l0;
        logic l1;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 1'b1, 12, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 12, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 12, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b0,  5, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 12, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 12, 1'b0, 1'b0};

        // 1. reset with keys released
        #2 rst_n = 1'b0;
        ticks(10);
        check("t1_reset_outputs",
              int'({o_key0, o_key1, o_key0_press, o_key0_rel, o_key1_press, o_key1_rel}), 0);
        #4 rst_n = 1'b1;
        ticks(3);

        // 2. clean press of key0
        key0 = 1'b0;
        wait_flip(0, 1'b1, 10, "t2_press");
        check("t2_key1_idle", int'({o_key1, o_key1_press, o_key1_rel}), 0);
        tick();
        check("t2_press_one_cycle", int'(o_key0_press), 0);
        key0 = 1'b1;
        ticks(12);

        // 3. bouncing press: low phases 3, 5, 7
        p0cnt = 0;
        key0 = 1'b0; ticks(3);
        key0 = 1'b1; ticks(3);
        key0 = 1'b0; ticks(5);
        key0 = 1'b1; ticks(3);
        key0 = 1'b0; ticks(7);
        key0 = 1'b1; ticks(3);
        check("t3_no_bounce_pulse", p0cnt, 0);
        key0 = 1'b0;
        wait_flip(0, 1'b1, 10, "t3_press");
        ticks(3);
        check("t3_single_press", p0cnt, 1);

        // 4. release with a 4-cycle glitch after 2 cycles
        r0cnt = 0;
        key0 = 1'b1; ticks(2);
        key0 = 1'b0; ticks(4);
        key0 = 1'b1;
        wait_flip(0, 1'b0, 10, "t4_rel");
        ticks(3);
        check("t4_single_rel", r0cnt, 1);

        // 5. simultaneous press
        key0 = 1'b0; key1 = 1'b0;
        wait_flip(0, 1'b1, 10, "t5_press0");
        check("t5_press1_same_cycle", int'(o_key1_press), 1);
        ticks(2);
        check("t5_both_levels", int'({o_key0, o_key1}), 3);

        // 6. reset while key1 is held
        key0 = 1'b1;
        ticks(12);
        check("t6_key1_before_reset", int'(o_key1), 1);
        #4 rst_n = 1'b0;
        #1;
        check("t6_async_clear", int'({o_key0, o_key1, o_key1_press, o_key1_rel}), 0);
        ticks(3);
        #4 rst_n = 1'b1;
        wait_flip(1, 1'b1, 10, "t6_requalify");

        // table-driven level checks
        for (int i = 0; i < 6; i++) begin
            key0 = vecs[i].k0;
            key1 = vecs[i].k1;
            ticks(vecs[i].cycles);
            check($sformatf("vec%0d_levels", i), int'({o_key0, o_key1}),
                  int'({vecs[i].l0, vecs[i].l1}));
        end

        // randomized segments against the model, with occasional resets
        for (int seg = 0; seg < 90; seg++) begin
            key0 = 1'($urandom_range(0, 1));
            key1 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) begin
                #4 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            ticks(int'($urandom_range(1, 13)));
        end
        key0 = 1'b1; key1 = 1'b1;
        ticks(14);
        check("final_released", int'({o_key0, o_key1}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Two-channel push-button conditioner that sits directly upstream of the switch-to-LED logic.
- Takes raw, asynchronous, bouncing board keys and synchronises them to the system clock.
- Filters bounce with per-key counter state machines.
- Delivers clean active-high key levels, plus single-cycle press and release pulses, to the LED stage.

Parameters:
- DEBOUNCE_CNT, 1000000, consecutive stable cycles required to accept a key change (20 ms at 50 MHz); legal range 2..2^24.
- KEY_ACTIVE_LOW, 1, 1: raw key reads 0 when pressed (board default); 0: raw key reads 1 when pressed.

Ports:
- i_clk  input  1  system clock (50 MHz on board).
- i_rst_n  input  1  asynchronous, active-low reset.
- i_key0  input  1  raw key 0 from pin, asynchronous, bouncing.
- i_key1  input  1  raw key 1 from pin, asynchronous, bouncing.
- o_key0  output  1  debounced key 0 level, 1 = pressed.
- o_key1  output  1  debounced key 1 level, 1 = pressed.
- o_key0_press  output  1  one-cycle pulse on accepted key 0 press.
- o_key0_rel  output  1  one-cycle pulse on accepted key 0 release.
- o_key1_press  output  1  one-cycle pulse on accepted key 1 press.
- o_key1_rel  output  1  one-cycle pulse on accepted key 1 release.

Behaviour:
- Clock and reset:
  - One clock domain: i_clk.
  - Reset is asynchronous assert, active-low (i_rst_n = 0).
  - Release of i_rst_n is synchronous to i_clk; the bench deasserts it away from clock edges.
- Reset values:
  - All outputs 0.
  - Synchroniser flops at the "released" raw level (1 if KEY_ACTIVE_LOW = 1, else 0).
  - Counters 0; FSMs in UP.
- Synchroniser:
  - Each key passes through 2 flops, then is normalised to pressed = 1 (inverted when KEY_ACTIVE_LOW = 1).
  - The result is s0/s1.
  - Nothing downstream samples the raw pins.
- Per-key FSM, identical and independent for both keys. Counter width = clog2(DEBOUNCE_CNT).
  - UP: output level 0. If s = 1, go to WAIT_DN with cnt = 1; otherwise stay.
  - WAIT_DN:
    - s = 0: return to UP, cnt = 0 (bounce rejected, no pulse).
    - s = 1 and cnt = DEBOUNCE_CNT-1: go to DOWN. On the same edge the level goes to 1 and the press pulse is registered high.
    - Otherwise cnt increments.
  - DOWN: level 1. If s = 0, go to WAIT_UP with cnt = 1.
  - WAIT_UP:
    - s = 1: return to DOWN, cnt = 0.
    - s = 0 and cnt = DEBOUNCE_CNT-1: go to UP. Level goes to 0 and the release pulse is high.
    - Otherwise cnt increments.
- Outputs:
  - All registered.
  - Pulses are high for exactly one i_clk cycle, then return to 0.
- Latency:
  - A clean raw edge appears on the level output 2 + DEBOUNCE_CNT rising edges after the first edge that samples the new raw value.
  - The pulse coincides with the level change.
- Pulse-width rule:
  - Any excursion of s shorter than DEBOUNCE_CNT cycles produces no level change and no pulse.
  - The counter restarts from 1 on each new excursion; there is no accumulation across bounces.
- Simultaneous events:
  - Both keys may qualify on the same edge; both pulses assert in the same cycle.
  - No arbitration between keys.
- Mutual exclusion: press and release pulses of one key are never high together.
- Reset mid-count:
  - Asserting i_rst_n mid-count immediately forces all outputs 0 and the FSM to UP, even if the level was 1.
  - A key still held after reset must re-qualify for the full 2 + DEBOUNCE_CNT cycles, then emits a press pulse.
- Counter: never exceeds DEBOUNCE_CNT-1 and never wraps.

Test Plan:
Use DEBOUNCE_CNT = 8, KEY_ACTIVE_LOW = 1, 20 ns clock.
1. Reset with keys released (raw 1), hold 10 cycles -> all six outputs 0 throughout; no pulses.
2. i_key0 driven 1->0 cleanly and held -> o_key0 rises exactly 10 cycles after the first sampling edge; o_key0_press is high for 1 cycle in that same cycle; o_key1* stay 0.
3. i_key0 bounces 0/1 with low phases of 3, 5 and 7 cycles, then holds low -> no pulse during the bounces; o_key0_press fires once, 10 cycles after the final falling edge.
4. From pressed, i_key0 released 0->1 with a 4-cycle glitch back to 0 after 2 cycles, then held 1 -> single o_key0_rel pulse, 10 cycles after the final rising edge; o_key0 goes 0 in the same cycle.
5. i_key0 and i_key1 pressed on the same edge -> o_key0_press and o_key1_press assert in the same cycle; o_key0 and o_key1 are 1 together afterwards.
6. With key1 held pressed and o_key1 = 1, assert i_rst_n low for 3 cycles mid-operation -> o_key1 goes 0 asynchronously. After release, o_key1 returns to 1 with a press pulse 10 cycles after the first post-reset edge.
